// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to a
// variable-latency instruction memory and buffers the fetched word for decode.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_done,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] inst,
    output logic [15:0] pc_plus2,
    output logic        inst_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        WAIT_SLOT,
        HALT
    } state_t;

    // Decode-facing output register; link is the halfword address of inst + 2.
    typedef struct packed {
        logic        valid;
        logic [15:0] word;
        logic [15:1] link;
    } slot_t;

    state_t      state, state_n;
    logic [15:1] pc, pc_n, pc_inc;
    logic [15:1] addr_q;
    logic [15:0] hold, hold_n;
    slot_t       slot, slot_n;
    logic        slot_free;
    logic        unused_bits;

    assign pc_inc      = pc + 15'd1;
    assign slot_free   = !slot.valid || !stall;
    assign unused_bits = redirect_pc[0];

    function automatic logic is_halt(input logic [15:0] w);
        return w[15:11] == 5'b00000;
    endfunction

    always_comb begin
        state_n = state;
        pc_n    = pc;
        hold_n  = hold;
        slot_n  = slot;

        if (slot.valid && !stall) begin
            slot_n.valid = 1'b0;
            slot_n.word  = NOP_INST;
        end

        if (redirect) begin
            slot_n.valid = 1'b0;
            slot_n.word  = NOP_INST;
            hold_n       = NOP_INST;
            pc_n         = redirect_pc[15:1];
            // An outstanding request must finish before the new target is issued.
            case (state)
                FETCH, DRAIN: state_n = imem_done ? FETCH : DRAIN;
                default:      state_n = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_done) begin
                        pc_n = pc_inc;
                        if (slot_free) begin
                            slot_n  = '{valid: 1'b1, word: imem_rdata, link: pc_inc};
                            state_n = is_halt(imem_rdata) ? HALT : FETCH;
                        end else begin
                            hold_n  = imem_rdata;
                            state_n = WAIT_SLOT;
                        end
                    end
                end
                WAIT_SLOT: begin
                    // pc already points past the held word, so it is the link value.
                    if (!stall) begin
                        slot_n  = '{valid: 1'b1, word: hold, link: pc};
                        state_n = is_halt(hold) ? HALT : FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_done) state_n = FETCH;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= RESET_PC[15:1];
            addr_q <= RESET_PC[15:1];
            hold   <= NOP_INST;
            slot   <= '{valid: 1'b0, word: NOP_INST, link: RESET_PC[15:1] + 15'd1};
        end else begin
            state <= state_n;
            pc    <= pc_n;
            hold  <= hold_n;
            slot  <= slot_n;
            // Address only moves when a fresh request begins; DRAIN keeps the old one.
            if (state_n == FETCH) addr_q <= pc_n;
        end
    end

    assign imem_req   = (state == FETCH || state == DRAIN) && !rst;
    assign imem_addr  = {addr_q, 1'b0};
    assign inst       = slot.valid ? slot.word : NOP_INST;
    assign inst_valid = slot.valid;
    assign pc_plus2   = {slot.link, 1'b0};
    assign halted     = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: program-order model of presented instructions, a
// variable-latency memory responder and directed literal checks.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_done = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] inst;
    logic [15:0] pc_plus2;
    logic        inst_valid;
    logic        halted;

    int checks = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(16'h0000), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_done(imem_done), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst(inst), .pc_plus2(pc_plus2), .inst_valid(inst_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: mem_word = 16'h4001;
            16'h0002: mem_word = 16'h4802;
            16'h0004: mem_word = 16'hD800;
            16'h0008: mem_word = 16'h0000;
            default:  mem_word = {5'b00011, a[11:1]};
        endcase
    endfunction

    function automatic int lat_of(input logic [15:0] a);
        return (a == 16'h0006 || a == 16'h0010) ? 3 : 0;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: each newly presented instruction must be the next in program
    // order from the last redirect/reset; nothing may appear after a HALT.
    logic [15:0] exp_pc = 16'h0000;
    logic [15:0] exp_w;
    logic [15:0] last_inst, last_p2;
    bit          shown = 0, mhalt = 0, chk_en = 0;
    bit          prev_req = 0, prev_done = 0;
    logic [15:0] prev_addr = 16'h0000;
    int          cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst) check1("req_in_reset", imem_req, 1'b0);
            if (prev_req && !prev_done && imem_req)
                check16("addr_stable", imem_addr, prev_addr);
            if (!inst_valid) begin
                check16("bubble", inst, NOP);
            end else if (!shown) begin
                check1("present_after_halt", mhalt, 1'b0);
                exp_w = mem_word(exp_pc);
                check16("inst", inst, exp_w);
                check16("pc_plus2", pc_plus2, exp_pc + 16'd2);
                if (exp_w[15:11] == 5'b00000) mhalt = 1;
                last_inst = exp_w;
                last_p2   = exp_pc + 16'd2;
                exp_pc    = exp_pc + 16'd2;
                shown     = 1;
            end else begin
                check16("inst_hold", inst, last_inst);
                check16("p2_hold", pc_plus2, last_p2);
            end
            check1("halted", halted, mhalt);
            if (mhalt) check1("req_while_halted", imem_req, 1'b0);
        end
        if (rst) begin
            exp_pc = 16'h0000; shown = 0; mhalt = 0;
        end else if (redirect) begin
            exp_pc = {redirect_pc[15:1], 1'b0}; shown = 0; mhalt = 0;
        end else if (inst_valid && !stall) begin
            shown = 0;
        end
        prev_req  = imem_req;
        prev_addr = imem_addr;
        if (imem_req) begin
            imem_rdata = mem_word(imem_addr);
            imem_done  = (cnt >= lat_of(imem_addr));
            cnt        = imem_done ? 0 : cnt + 1;
        end else begin
            imem_done = 1'b0;
            cnt       = 0;
        end
        prev_done = imem_done;
    end

    bit [15:0] pat = 16'b0110_0011_1010_0110;

    initial begin
        tick(2);
        check16("rst_inst", inst, NOP);
        check1("rst_valid", inst_valid, 1'b0);
        check16("rst_p2", pc_plus2, 16'h0002);
        check1("rst_halted", halted, 1'b0);
        check1("rst_req", imem_req, 1'b0);
        chk_en = 1;
        rst = 1'b0;

        // zero-wait stream from 0, then 3-cycle wait at 6, then HALT at 8
        tick(1); check16("a0_inst", inst, 16'h4001); check16("a0_p2", pc_plus2, 16'h0002);
        check16("a0_addr", imem_addr, 16'h0002);
        tick(1); check16("a1_inst", inst, 16'h4802); check16("a1_p2", pc_plus2, 16'h0004);
        tick(1); check16("a2_inst", inst, 16'hD800); check16("a2_p2", pc_plus2, 16'h0006);
        check16("a2_addr", imem_addr, 16'h0006);
        for (int i = 0; i < 3; i++) begin
            tick(1); check16("wait_addr", imem_addr, 16'h0006); check1("wait_req", imem_req, 1'b1);
        end
        tick(1); check16("a6_inst", inst, 16'h1803); check16("a6_p2", pc_plus2, 16'h0008);
        tick(1); check16("halt_inst", inst, 16'h0000); check16("halt_p2", pc_plus2, 16'h000A);
        check1("halt_flag", halted, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick(1); check1("halt_noreq", imem_req, 1'b0);
        end

        // resume after HALT, then stall across a completing fetch
        redirect = 1'b1; redirect_pc = 16'h0020;
        tick(1); redirect = 1'b0;
        check1("resume_halted", halted, 1'b0); check16("resume_addr", imem_addr, 16'h0020);
        tick(1); check16("d1_inst", inst, 16'h1810); check16("d1_p2", pc_plus2, 16'h0022);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1); check1("slot_noreq", imem_req, 1'b0); check16("slot_inst", inst, 16'h1810);
        end
        tick(1); stall = 1'b0; check16("d6_inst", inst, 16'h1810);
        tick(1); check16("d7_inst", inst, 16'h1811); check16("d7_p2", pc_plus2, 16'h0024);

        // redirect while a slow request is pending -> DRAIN
        redirect = 1'b1; redirect_pc = 16'h0010;
        tick(1); redirect = 1'b0; check16("e0_addr", imem_addr, 16'h0010);
        tick(1); redirect = 1'b1; redirect_pc = 16'h0101;
        tick(1); redirect = 1'b0;
        check1("e2_valid", inst_valid, 1'b0); check16("e2_addr", imem_addr, 16'h0010);
        tick(1); check1("e3_valid", inst_valid, 1'b0); check16("e3_addr", imem_addr, 16'h0010);
        tick(1); check1("e4_valid", inst_valid, 1'b0); check16("e4_addr", imem_addr, 16'h0100);
        tick(1); check16("e5_inst", inst, 16'h1880); check16("e5_p2", pc_plus2, 16'h0102);

        // PC wrap
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick(1); redirect = 1'b0; check16("f0_addr", imem_addr, 16'hFFFE);
        tick(1); check16("wrap_inst", inst, 16'h1FFF); check16("wrap_p2", pc_plus2, 16'h0000);
        check16("wrap_addr", imem_addr, 16'h0000);
        tick(1); check16("f2_inst", inst, 16'h4001); check16("f2_p2", pc_plus2, 16'h0002);

        // reset during DRAIN
        redirect = 1'b1; redirect_pc = 16'h0010;
        tick(1); redirect_pc = 16'h0040;
        tick(1); redirect = 1'b0; check16("g1_addr", imem_addr, 16'h0010);
        rst = 1'b1;
        tick(1);
        check1("g2_valid", inst_valid, 1'b0); check1("g2_halted", halted, 1'b0);
        check16("g2_inst", inst, NOP); check16("g2_p2", pc_plus2, 16'h0002);
        check1("g2_req", imem_req, 1'b0);
        rst = 1'b0;
        #1 check16("g2_addr", imem_addr, 16'h0000);
        tick(1); check16("g3_inst", inst, 16'h4001); check16("g3_p2", pc_plus2, 16'h0002);

        // mixed stall pattern runs through to the HALT at 8
        for (int i = 0; i < 16; i++) begin
            stall = pat[i];
            tick(1);
        end
        stall = 1'b0;
        tick(30);
        check1("end_halted", halted, 1'b1);
        check1("end_valid", inst_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
